ram_sync_nolatch_nrmw: RTL

RAM_SYNC_NOLATCH_NRMW -- requirements
Module: ram_sync_nolatch_nrmw

---
 rtl/ram_sync_nolatch_nrmw.sv | 99 +++++++++
 1 files changed

// File: rtl/ram_sync_nolatch_nrmw.sv
// ram_sync_nolatch_nrmw: multi-port register-file RAM with zeroing sweep after reset/init_req
// Ports: clk, reset (async, active-high); raddr/rdata packed NR read lanes (combinational);
//   waddr/wdata/we packed NW write ports (rising edge, highest index wins);
//   init_req starts a zeroing sweep from READY; ready marks READY; wr_conflict is a
//   registered pulse after a same-address multi-write.
// Macro RAM_WR_BYPASS_EN: reads see same-cycle write data (write-first); default read-first.
module ram_sync_nolatch_nrmw #(
    parameter int NR    = 2,
    parameter int NW    = 2,
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NR*AW-1:0] raddr,
    output logic [NR*DW-1:0] rdata,
    input  logic [NW*AW-1:0] waddr,
    input  logic [NW*DW-1:0] wdata,
    input  logic [NW-1:0]    we,
    input  logic             init_req,
    output logic             ready,
    output logic             wr_conflict
);
    typedef enum logic {INIT, READY} state_t;
    localparam logic [AW:0]   LIM  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    state_t          state, state_n;
    logic [AW-1:0]   init_cnt, cnt_n;
    logic            conflict;
    logic [AW-1:0]   ra;
    logic [DW-1:0]   rd;
    // Sized to the full address space so every address indexes cleanly;
    // entries at or above DEPTH are never written or returned.
    logic [DW-1:0]   mem [0:(1<<AW)-1];

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < LIM;
    endfunction

    assign ready = (state == READY);

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state       <= INIT;
            init_cnt    <= '0;
            wr_conflict <= 1'b0;
        end else begin
            state       <= state_n;
            init_cnt    <= cnt_n;
            wr_conflict <= conflict;
        end

    always_comb begin
        state_n = state;
        cnt_n   = init_cnt;
        if (state == INIT) begin
            state_n = (init_cnt == LAST) ? READY : INIT;
            cnt_n   = (init_cnt == LAST) ? '0 : init_cnt + 1'b1;
        end else if (init_req) begin
            state_n = INIT;
            cnt_n   = '0;
        end
    end

    always_comb begin
        conflict = 1'b0;
        for (int j = 0; j < NW; j++)
            for (int k = j + 1; k < NW; k++)
                if (state == READY && we[j] && we[k] && in_range(waddr[j*AW +: AW])
                    && waddr[j*AW +: AW] == waddr[k*AW +: AW])
                    conflict = 1'b1;
    end

    // Later loop iterations override earlier ones, so the highest-index port wins.
    always_ff @(posedge clk)
        if (state == INIT)
            mem[init_cnt] <= '0;
        else
            for (int j = 0; j < NW; j++)
                if (we[j] && in_range(waddr[j*AW +: AW]))
                    mem[waddr[j*AW +: AW]] <= wdata[j*DW +: DW];

    always_comb begin
        rdata = '0;
        ra    = '0;
        rd    = '0;
        for (int i = 0; i < NR; i++) begin
            ra = raddr[i*AW +: AW];
            rd = mem[ra];
`ifdef RAM_WR_BYPASS_EN
            for (int j = 0; j < NW; j++)
                if (we[j] && waddr[j*AW +: AW] == ra)
                    rd = wdata[j*DW +: DW];
`endif
            rdata[i*DW +: DW] = (state == READY && in_range(ra)) ? rd : '0;
        end
    end
endmodule
